// File: rtl/byte_piso_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : byte_piso_tx_if
//  Description : Signal bundle for the byte_piso_tx serializer.
//                - Byte side   : data_byte_i / valid_byte_i / ready_byte_o
//                - Serial side : en_i / data_serial_o / valid_serial_o
//                - Status      : busy_o / fifo_level_o
//                The slave modport is the serializer; the master modport is
//                whatever feeds bytes and consumes the serial stream.
//  Revision    : 1.0 - initial release
// ============================================================================
interface byte_piso_tx_if;
    logic [7:0] data_byte_i;
    logic       valid_byte_i;
    logic       ready_byte_o;
    logic       en_i;
    logic       data_serial_o;
    logic       valid_serial_o;
    logic       busy_o;
    logic [2:0] fifo_level_o;

    modport slave (
        input  data_byte_i,
        input  valid_byte_i,
        input  en_i,
        output ready_byte_o,
        output data_serial_o,
        output valid_serial_o,
        output busy_o,
        output fifo_level_o
    );

    modport master (
        output data_byte_i,
        output valid_byte_i,
        output en_i,
        input  ready_byte_o,
        input  data_serial_o,
        input  valid_serial_o,
        input  busy_o,
        input  fifo_level_o
    );
endinterface
`default_nettype wire

// File: rtl/byte_piso_tx.sv
`default_nettype none
// ============================================================================
//  Module      : byte_piso_tx
//  Description : Byte-wide parallel-in / serial-out transmitter with a small
//                byte FIFO in front of an 8-bit shift register. Bits leave
//                LSB first, one per cycle in which en_i is high.
//  Ports       : clk    - rising-edge clock
//                rst_n  - asynchronous active-low reset
//                bus    - byte_piso_tx_if.slave
//                         data_byte_i/valid_byte_i/ready_byte_o : byte input
//                         en_i                                  : bit-rate enable
//                         data_serial_o/valid_serial_o          : serial output
//                         busy_o                                : holding data
//                         fifo_level_o                          : FIFO occupancy
//  Parameters  : DEPTH  - FIFO entries (level is 3 bits wide, so DEPTH <= 7)
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_piso_tx #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    byte_piso_tx_if.slave bus
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    logic [7:0]         r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [2:0]         r_level;

    state_t             r_state;
    logic [7:0]         r_shift;
    logic [2:0]         r_cnt;
    logic               r_data_serial;
    logic               r_valid_serial;

    // ------------------------------------------------------------------------
    // Handshake and pop decode
    // ------------------------------------------------------------------------
    logic               w_ready;
    logic               w_push;
    logic               w_fifo_nempty;
    logic               w_last_bit;
    logic               w_pop;
    logic [7:0]         w_head;

    // Ready comes only from the registered level, so a pop in the same cycle
    // never opens a slot early and there is no valid->ready combinational path.
    assign w_ready       = (r_level < 3'(DEPTH));
    assign w_push        = bus.valid_byte_i & w_ready;
    assign w_fifo_nempty = (r_level != 3'd0);

    // Edge that emits bit 7 of the current byte.
    assign w_last_bit    = (r_state == S_SHIFT) & bus.en_i & (r_cnt == 3'd7);

    // Pop either to start from idle (independent of en_i) or to reload on the
    // last-bit edge so consecutive bytes run without a bubble.
    assign w_pop         = w_fifo_nempty & ((r_state == S_IDLE) | w_last_bit);
    assign w_head        = r_mem[r_rd_ptr];

    function automatic logic [c_ptr_w-1:0] f_next_ptr(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + c_ptr_w'(1);
    endfunction

    // ------------------------------------------------------------------------
    // FIFO: data array has no reset; pointers and level carry all state.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.data_byte_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= 3'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
            end
            // Simultaneous push and pop leaves the level unchanged.
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 3'd1;
                2'b01:   r_level <= r_level - 3'd1;
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Serializer FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_shift        <= 8'h00;
            r_cnt          <= 3'd0;
            r_data_serial  <= 1'b0;
            r_valid_serial <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_valid_serial <= 1'b0;
                    if (w_fifo_nempty) begin
                        r_shift <= w_head;
                        r_cnt   <= 3'd0;
                        r_state <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (bus.en_i) begin
                        r_data_serial  <= r_shift[0];
                        r_valid_serial <= 1'b1;
                        r_shift        <= {1'b0, r_shift[7:1]};
                        r_cnt          <= r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            if (w_fifo_nempty) begin
                                // Reload overrides the shift so the next byte
                                // starts on the following enabled edge.
                                r_shift <= w_head;
                                r_cnt   <= 3'd0;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                    end else begin
                        // Stall: hold shift, count and serial data bit.
                        r_valid_serial <= 1'b0;
                    end
                end

                default: begin
                    r_state        <= S_IDLE;
                    r_valid_serial <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.ready_byte_o   = w_ready;
    assign bus.data_serial_o  = r_data_serial;
    assign bus.valid_serial_o = r_valid_serial;
    assign bus.busy_o         = (r_state == S_SHIFT) | w_fifo_nempty;
    assign bus.fifo_level_o   = r_level;

endmodule
`default_nettype wire

// File: tb/tb_byte_piso_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_byte_piso_tx
//  Description : Directed self-checking bench for byte_piso_tx. A monitor
//                collects every valid serial bit with its cycle stamp; the
//                scenarios compare the collected stream and status outputs
//                against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_piso_tx;

    logic clk = 1'b0;
    logic rst_n;

    byte_piso_tx_if bus();

    byte_piso_tx #(.DEPTH(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit q_bits[$];
    int q_cyc[$];

    // Monitor samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (bus.valid_serial_o === 1'b1) begin
            q_bits.push_back(bus.data_serial_o);
            q_cyc.push_back(cyc);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Main flow observes/drives 2 units after the edge, after the monitor.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_bits(input int n, input int budget, input string tag);
        int k = 0;
        while (q_bits.size() < n && k < budget) begin
            tick();
            k++;
        end
        check_val(tag, q_bits.size(), n);
    endtask

    function automatic logic [7:0] get_byte(input int base);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (base + i < q_bits.size()) b[i] = q_bits[base + i];
        end
        return b;
    endfunction

    task automatic clear_q();
        q_bits.delete();
        q_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int accepted;
        int viol;
        int found;
        logic rdy;
        logic en_applied;
        logic rdy_at_6;

        rst_n            = 1'b0;
        bus.data_byte_i  = 8'h00;
        bus.valid_byte_i = 1'b0;
        bus.en_i         = 1'b0;

        // ---------------- Reset values ----------------
        #12;
        check_val("rst_valid", bus.valid_serial_o, 1'b0);
        check_val("rst_data",  bus.data_serial_o,  1'b0);
        check_val("rst_busy",  bus.busy_o,         1'b0);
        check_val("rst_level", bus.fifo_level_o,   3'd0);
        check_val("rst_ready", bus.ready_byte_o,   1'b1);
        rst_n = 1'b1;
        tick();

        // ---------------- Single byte 0xA5 ----------------
        clear_q();
        bus.en_i         = 1'b1;
        bus.data_byte_i  = 8'hA5;
        bus.valid_byte_i = 1'b1;
        tick();
        c0 = cyc;
        bus.valid_byte_i = 1'b0;
        check_val("a5_level_after_push", bus.fifo_level_o, 3'd1);
        check_val("a5_busy_after_push",  bus.busy_o, 1'b1);
        wait_bits(8, 40, "a5_bit_count");
        check_val("a5_byte", get_byte(0), 8'hA5);
        check_val("a5_first_bit_latency", q_cyc[0] - c0, 2);
        check_val("a5_contiguous", q_cyc[7] - q_cyc[0], 7);
        tick();
        check_val("a5_valid_after", bus.valid_serial_o, 1'b0);
        check_val("a5_busy_after",  bus.busy_o, 1'b0);
        check_val("a5_no_extra_bits", q_bits.size(), 8);
        tick();

        // ---------------- Back-to-back 0x3C, 0xC3 ----------------
        clear_q();
        bus.data_byte_i  = 8'h3C;
        bus.valid_byte_i = 1'b1;
        tick();
        bus.data_byte_i  = 8'hC3;
        tick();
        bus.valid_byte_i = 1'b0;
        check_val("b2b_level_pushpop", bus.fifo_level_o, 3'd1);
        wait_bits(16, 60, "b2b_bit_count");
        check_val("b2b_stream", {get_byte(8), get_byte(0)}, 16'hC33C);
        check_val("b2b_no_gap", q_cyc[15] - q_cyc[0], 15);
        tick();
        tick();
        check_val("b2b_busy_end", bus.busy_o, 1'b0);

        // ---------------- Fill with en_i=0 ----------------
        clear_q();
        bus.en_i = 1'b0;
        accepted = 0;
        rdy_at_6 = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            bus.data_byte_i  = 8'(i);
            bus.valid_byte_i = 1'b1;
            rdy = bus.ready_byte_o;
            if (i == 6) rdy_at_6 = rdy;
            tick();
            if (rdy) accepted++;
        end
        tick();
        tick();
        bus.valid_byte_i = 1'b0;
        tick();
        check_val("fill_accepted", accepted, 5);
        check_val("fill_ready_at_06", rdy_at_6, 1'b0);
        check_val("fill_level", bus.fifo_level_o, 3'd4);
        check_val("fill_ready", bus.ready_byte_o, 1'b0);
        check_val("fill_busy", bus.busy_o, 1'b1);
        check_val("fill_no_serial", q_bits.size(), 0);

        // ---------------- Drain ----------------
        bus.en_i = 1'b1;
        found = 0;
        for (int k = 0; k < 100 && q_bits.size() < 40; k++) begin
            tick();
            if (found == 0 && bus.fifo_level_o == 3'd3) begin
                found = 1;
                check_val("drain_ready_back", bus.ready_byte_o, 1'b1);
                check_val("drain_first_pop_at_bit7", q_bits.size(), 8);
            end
        end
        check_val("drain_pop_seen", found, 1);
        check_val("drain_bit_count", q_bits.size(), 40);
        for (int b = 0; b < 5; b++) begin
            check_val($sformatf("drain_byte%0d", b), get_byte(8 * b), 8'(b + 1));
        end
        check_val("drain_no_gap", q_cyc[39] - q_cyc[0], 39);
        tick();
        tick();
        check_val("drain_level_end", bus.fifo_level_o, 3'd0);
        check_val("drain_busy_end", bus.busy_o, 1'b0);
        check_val("drain_no_extra", q_bits.size(), 40);

        // ---------------- Throttle 0xF0 ----------------
        clear_q();
        viol = 0;
        for (int i = 0; i < 40; i++) begin
            bus.en_i = (i % 2 == 0);
            if (i == 0) begin
                bus.data_byte_i  = 8'hF0;
                bus.valid_byte_i = 1'b1;
            end else begin
                bus.valid_byte_i = 1'b0;
            end
            en_applied = bus.en_i;
            tick();
            if (bus.valid_serial_o && !en_applied) viol++;
        end
        bus.valid_byte_i = 1'b0;
        check_val("thr_pulse_on_enabled_only", viol, 0);
        check_val("thr_bit_count", q_bits.size(), 8);
        check_val("thr_byte", get_byte(0), 8'hF0);
        check_val("thr_spaced", q_cyc[7] - q_cyc[0], 14);

        // ---------------- Reset mid-byte ----------------
        clear_q();
        bus.en_i         = 1'b1;
        bus.valid_byte_i = 1'b1;
        bus.data_byte_i  = 8'h5A;
        tick();
        bus.data_byte_i  = 8'h11;
        tick();
        bus.data_byte_i  = 8'h22;
        tick();
        bus.valid_byte_i = 1'b0;
        wait_bits(4, 20, "mid_bits_before_reset");
        check_val("mid_low_nibble", get_byte(0) & 8'h0F, 8'h0A);
        check_val("mid_queued", bus.fifo_level_o, 3'd2);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", bus.valid_serial_o, 1'b0);
        check_val("mid_rst_data",  bus.data_serial_o,  1'b0);
        check_val("mid_rst_busy",  bus.busy_o,         1'b0);
        check_val("mid_rst_level", bus.fifo_level_o,   3'd0);
        check_val("mid_rst_ready", bus.ready_byte_o,   1'b1);
        tick();
        tick();
        rst_n = 1'b1;
        clear_q();
        for (int i = 0; i < 20; i++) tick();
        check_val("post_rst_no_serial", q_bits.size(), 0);
        check_val("post_rst_busy", bus.busy_o, 1'b0);
        bus.data_byte_i  = 8'h81;
        bus.valid_byte_i = 1'b1;
        tick();
        bus.valid_byte_i = 1'b0;
        check_val("post_rst_accept", bus.fifo_level_o, 3'd1);
        wait_bits(8, 40, "post_rst_bit_count");
        check_val("post_rst_byte", get_byte(0), 8'h81);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/byte_piso_tx.md
BYTE_PISO_TX -- requirements
Module: byte_piso_tx

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: data_byte_i  input  8  byte to serialize.
REQ-004 SHALL have port: valid_byte_i  input  1  data_byte_i valid.
REQ-005 SHALL have port: ready_byte_o  output  1  block can accept a byte this cycle.
REQ-006 SHALL have port: en_i  input  1  serial-rate enable; one bit is emitted per enabled cycle.
REQ-007 SHALL have port: data_serial_o  output  1  serial bit, LSB first, registered.
REQ-008 SHALL have port: valid_serial_o  output  1  data_serial_o valid this cycle, registered.
REQ-009 SHALL have port: busy_o  output  1  serializer holds a byte, or the FIFO is non-empty.
REQ-010 SHALL have port: fifo_level_o  output  3  FIFO occupancy, 0..4.
REQ-011 SHALL have parameter: DEPTH, default 4, number of FIFO byte entries; only 4 is verified.

Function
REQ-012 SHALL accept a byte on a clock edge where valid_byte_i=1 and ready_byte_o=1, writing it to the FIFO tail.
REQ-013 SHALL drive ready_byte_o = (fifo_level < DEPTH), decoded from registered level only, never from valid_byte_i or a same-cycle pop.
REQ-014 SHALL ignore valid_byte_i while ready_byte_o=0; no FIFO or level change.
REQ-015 SHALL update the level as follows on simultaneous push and pop:
- level unchanged;
- FIFO order preserved;
- pointers wrap modulo DEPTH.
REQ-016 SHALL use two serializer states, IDLE and SHIFT, with a 3-bit bit counter.
REQ-017 SHALL, in IDLE with FIFO non-empty, pop the head into the shift register, set counter=0 and go to SHIFT on the same edge, regardless of en_i.
REQ-018 SHALL, in SHIFT with en_i=1, do the following on the edge:
- data_serial_o <= shift[0];
- valid_serial_o <= 1;
- shift right by one;
- counter++.
REQ-019 SHALL, in SHIFT with en_i=0, set valid_serial_o <= 0 and hold the shift register, counter and data_serial_o.
REQ-020 SHALL, on the edge that emits bit 7 (counter=7, en_i=1), act on the FIFO state as follows:
- FIFO non-empty: pop and reload in that same edge, stay in SHIFT, counter=0; no bubble between bytes;
- FIFO empty: go to IDLE.
REQ-021 SHALL drive valid_serial_o low in every cycle following an edge in which no bit was emitted.
REQ-022 SHALL have a first-bit latency of 2 edges: byte accepted at edge E0 on an empty, idle block, loaded at E1, bit 0 valid in the cycle after E2 (en_i=1 at E2).
REQ-023 SHALL sustain one bit per enabled cycle while the FIFO is refilled before the last bit of each byte is emitted.
REQ-024 SHALL never pop an empty FIFO and never emit a bit in IDLE.
REQ-025 SHALL keep fifo_level_o excluding the byte held in the shift register; total block capacity is DEPTH+1 bytes.
REQ-026 SHALL drive busy_o = (state==SHIFT) | (fifo_level != 0).

Reset
REQ-027 SHALL, on rst_n low, asynchronously force the following:
- state=IDLE, counter=0, shift register=0;
- FIFO pointers and level=0;
- data_serial_o=0, valid_serial_o=0, busy_o=0, fifo_level_o=0;
- ready_byte_o=1.
REQ-028 SHALL discard any partially serialized byte and all FIFO contents on reset; no bit is emitted until a new byte is accepted after release.
REQ-029 SHALL treat reset release synchronously: first acceptance is possible at the first rising edge with rst_n high.

Verification
REQ-030 SHALL cover single byte: push 0xA5, en_i=1 ->
- valid_serial_o high for 8 consecutive cycles;
- bits 1,0,1,0,0,1,0,1;
- a downstream LSB-first SIPO reassembles 0xA5;
- busy_o falls after the last bit.
REQ-031 SHALL cover back-to-back: push 0x3C then 0xC3 on consecutive cycles, en_i=1 ->
- 16 consecutive valid cycles with no gap;
- bits 0,0,1,1,1,1,0,0,1,1,0,0,0,0,1,1.
REQ-032 SHALL cover fill: en_i=0, valid_byte_i=1 with bytes 0x01..0x06 ->
- 5 bytes accepted (1 loaded, 4 in FIFO);
- fifo_level_o=4;
- ready_byte_o=0 for 0x06;
- valid_serial_o stays 0.
REQ-033 SHALL cover drain: from the full state above, set en_i=1 ->
- 40 valid bits;
- reassembled bytes 0x01..0x05 in order;
- ready_byte_o returns to 1 the cycle after the first pop.
REQ-034 SHALL cover throttle: push 0xF0, en_i toggled 1,0,1,0... ->
- valid_serial_o pulses only after enabled edges;
- 8 bits 0,0,0,0,1,1,1,1 with no loss or duplication.
REQ-035 SHALL cover reset mid-byte: assert rst_n low after bit 3 of 0x5A with 2 bytes queued ->
- all outputs go to reset values immediately;
- after release, no valid_serial_o until a new byte is pushed.
